// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state type and default sizing for the PWM generator
package pwm_pkg;

    typedef enum logic [1:0] {IDLE, RUN, STOP} pwm_state_t;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_PERIOD = 10;

endpackage

// File: rtl/pwm_gen_if.sv
// pwm_gen_if: duty-cycle valid/ready handshake between a controller and the PWM generator
interface pwm_gen_if
    import pwm_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic           duty_valid;
    logic [WIDTH:0] duty;
    logic           duty_ready;

    modport master (output duty_valid, output duty, input duty_ready);
    modport slave  (input duty_valid, input duty, output duty_ready);

endinterface

// File: rtl/pwm_gen_tick_edge.sv
// tick_edge: one-clk step pulse on each rising edge of the divided tick
module tick_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_in,
    output logic step
);

    logic tick_q;
    logic armed;

    // armed stays low for the first clk after reset so a tick already high at release is not an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            tick_q <= tick_in;
            armed  <= 1'b1;
        end
    end

    assign step = armed & tick_in & ~tick_q;

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: step-counted PWM with a single-slot duty buffer applied at period boundaries
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PERIOD = DEF_PERIOD
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick_in,
    input  logic      en,
    pwm_gen_if.slave  bus,
    output logic      pwm_out,
    output logic      period_start,
    output logic      running
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH:0]   FULL = (WIDTH + 1)'(PERIOD);

    pwm_state_t     state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH:0] active_duty;
    logic [WIDTH:0] active_nxt;
    logic [WIDTH:0] pending;
    logic           pend_full;
    logic           step;
    logic           wrap;
    logic           start;
    logic           load;
    logic           accept;
    logic           live_nxt;

    tick_edge u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick_in (tick_in),
        .step    (step)
    );

    assign wrap   = step && (cnt == LAST);
    // a wrap in STOP only starts a period when en came back in the same clk
    assign start  = (state == IDLE) ? en : wrap && (state == RUN || en);
    assign load   = start && pend_full;
    assign accept = bus.duty_valid && !pend_full;
    // low only when the block will sit in IDLE next clk
    assign live_nxt   = (state == IDLE) ? en : !(state == STOP && !en && wrap);
    assign cnt_nxt    = (state == IDLE || wrap) ? '0 : cnt + WIDTH'(step);
    assign active_nxt = load ? pending : active_duty;

    assign bus.duty_ready = !pend_full;

    // state, counter, duty buffering and registered outputs, all judged on next-cycle values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            active_duty  <= '0;
            pending      <= '0;
            pend_full    <= 1'b0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            running      <= 1'b0;
        end else begin
            case (state)
                IDLE:    state <= en ? RUN : IDLE;
                RUN:     state <= en ? RUN : STOP;
                default: state <= en ? RUN : (wrap ? IDLE : STOP);
            endcase
            cnt          <= cnt_nxt;
            active_duty  <= active_nxt;
            if (accept)
                pending <= (bus.duty > FULL) ? FULL : bus.duty;
            pend_full    <= accept || (pend_full && !load);
            pwm_out      <= live_nxt && ({1'b0, cnt_nxt} < active_nxt);
            period_start <= start;
            running      <= live_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed and randomized checks of pwm_gen against a step/period reference model
module tb_pwm_gen;

    localparam int W = 4;
    localparam int P = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_in = 1'b0;
    logic en = 1'b0;
    logic pwm_out;
    logic period_start;
    logic running;

    pwm_gen_if #(.WIDTH(W)) bus ();

    pwm_gen #(.WIDTH(W), .PERIOD(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_in      (tick_in),
        .en           (en),
        .bus          (bus),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .running      (running)
    );

    always #5 clk = ~clk;

    int errors;
    int checks;
    int hi_cnt;

    // reference model: mode 0 idle, 1 running, 2 finishing the last period
    int m_mode;
    int m_pos;
    int m_act;
    int m_pend;
    bit m_full;
    bit m_tprev;
    bit m_arm;
    bit m_took;
    bit e_start;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pos   = 0;
        m_act   = 0;
        m_pend  = 0;
        m_full  = 0;
        m_tprev = 0;
        m_arm   = 0;
        m_took  = 0;
        e_start = 0;
    endtask

    task automatic model_edge();
        bit step;
        bit last;
        bit begin_p;
        bit acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        step    = m_arm && tick_in && !m_tprev;
        m_tprev = tick_in;
        m_arm   = 1;
        acc     = bus.duty_valid && !m_full;
        last    = (m_mode != 0) && step && (m_pos == P - 1);
        begin_p = 0;
        if (m_mode == 0) begin
            if (en) begin
                m_mode  = 1;
                begin_p = 1;
            end
        end else begin
            m_pos = last ? 0 : m_pos + int'(step);
            if (m_mode == 1) begin
                begin_p = last;
                if (!en) m_mode = 2;
            end else if (en) begin
                m_mode  = 1;
                begin_p = last;
            end else if (last) begin
                m_mode = 0;
            end
        end
        if (begin_p && m_full) begin
            m_act  = m_pend;
            m_full = 0;
        end
        if (acc) begin
            m_pend = (int'(bus.duty) > P) ? P : int'(bus.duty);
            m_full = 1;
        end
        m_took  = acc;
        e_start = begin_p;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("pwm_out", pwm_out, (m_mode != 0 && m_pos < m_act) ? 1 : 0);
        chk("period_start", period_start, e_start);
        chk("running", running, (m_mode != 0) ? 1 : 0);
        chk("duty_ready", bus.duty_ready, !m_full);
        hi_cnt += int'(pwm_out);
        if (m_took) bus.duty_valid = 1'b0;
    endtask

    task automatic tick(int hi, int lo);
        tick_in = 1'b1;
        repeat (hi) cyc();
        tick_in = 1'b0;
        repeat (lo) cyc();
    endtask

    task automatic ticks(int n);
        repeat (n) tick(1, 1);
    endtask

    task automatic run_to_pos(int p);
        for (int i = 0; i < 2 * P && m_pos != p; i++) tick(1, 1);
    endtask

    task automatic offer(int d);
        bus.duty       = (W + 1)'(d);
        bus.duty_valid = 1'b1;
        cyc();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        hi_cnt = 0;
        model_reset();
        bus.duty_valid = 1'b0;
        bus.duty       = '0;
        repeat (3) cyc();
        chk("reset_ready", bus.duty_ready, 1);
        chk("reset_pwm", pwm_out, 0);
        rst_n = 1'b1;

        // duty 4 accepted in IDLE, then steady running
        offer(4);
        en = 1'b1;
        cyc();
        ticks(10);
        hi_cnt = 0;
        ticks(10);
        chk("high_duty4", hi_cnt, 8);

        // mid-period update to 7 waits for the next period
        run_to_pos(3);
        offer(7);
        chk("ready_drop", bus.duty_ready, 0);
        ticks(20);
        hi_cnt = 0;
        ticks(10);
        chk("high_duty7", hi_cnt, 14);

        // duty 0 for a period, then saturated 15 -> always high
        offer(0);
        run_to_pos(0);
        offer(15);
        hi_cnt = 0;
        ticks(9);
        chk("high_duty0", hi_cnt, 0);
        hi_cnt = 0;
        ticks(20);
        chk("high_duty_full", hi_cnt, 40);

        // stop request at step 3 finishes the period then idles
        offer(4);
        run_to_pos(0);
        run_to_pos(3);
        en = 1'b0;
        ticks(7);
        chk("stop_running", running, 0);
        chk("stop_pwm", pwm_out, 0);
        ticks(3);
        chk("idle_pwm", pwm_out, 0);

        // stop then resume mid-period continues seamlessly
        en = 1'b1;
        cyc();
        run_to_pos(3);
        en = 1'b0;
        run_to_pos(6);
        en = 1'b1;
        ticks(4);
        hi_cnt = 0;
        ticks(10);
        chk("high_resume", hi_cnt, 8);

        // asynchronous reset mid-period with a pending duty
        offer(7);
        run_to_pos(5);
        chk("pend_full", bus.duty_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pwm", pwm_out, 0);
        chk("async_start", period_start, 0);
        chk("async_running", running, 0);
        chk("async_ready", bus.duty_ready, 1);
        model_reset();
        tick_in = 1'b1;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        tick_in = 1'b0;
        cyc();
        offer(3);
        ticks(12);

        // tick held high for 20 clk is a single step
        run_to_pos(2);
        tick(20, 2);
        ticks(10);

        // randomized traffic
        repeat (250) begin
            en = ($urandom_range(0, 9) != 0);
            if (!bus.duty_valid && $urandom_range(0, 3) == 0) begin
                bus.duty       = (W + 1)'($urandom_range(0, 31));
                bus.duty_valid = 1'b1;
            end
            tick($urandom_range(1, 3), $urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 Parameter WIDTH, default 4, is the period counter width in bits.
REQ-002 Parameter PERIOD, default 10, is the steps per PWM period; legal range 2..2^WIDTH.
REQ-003 clk  input  1  single system clock; all state on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 tick_in  input  1  divided-clock square wave from the upstream clock divider, synchronous to clk.
REQ-006 en  input  1  run request.
REQ-007 duty_valid  input  1  new duty value offered.
REQ-008 duty  input  WIDTH+1  high-time in steps; 0..PERIOD meaningful.
REQ-009 duty_ready  output  1  pending slot empty; the block accepts duty this cycle.
REQ-010 pwm_out  output  1  registered PWM output.
REQ-011 period_start  output  1  one-clk pulse when a new period begins.
REQ-012 running  output  1  high in states RUN and STOP.

Function
REQ-013 step = tick_in AND NOT tick_q, where tick_q is tick_in delayed one clk; one step per tick_in rising edge.
REQ-014 States: IDLE, RUN, STOP.
REQ-015 IDLE: cnt held 0, pwm_out 0; en=1 moves to RUN on the next clk and starts a period.
REQ-016 RUN: on step, cnt increments; at cnt=PERIOD-1, step wraps cnt to 0 and starts a period.
REQ-017 RUN with en=0: moves to STOP; counting continues.
REQ-018 STOP with en=1: returns to RUN with no disturbance to cnt or pwm_out.
REQ-019 STOP, wrapping step: moves to IDLE, cnt=0, no period start, no period_start pulse.
REQ-020 Period start (IDLE->RUN, or wrap in RUN):
- period_start pulses for exactly one clk.
- If pending is full, active_duty loads from pending and pending empties in the same clk.
REQ-021 Handshake: accept when duty_valid=1 and duty_ready=1.
- Accepted value is saturated to PERIOD and stored in pending.
- duty_ready = NOT pend_full.
REQ-022 Accept in the same clk as a period start that finds pending empty: the value goes to pending and applies at the next period start.
REQ-023 pwm_out <= (state is RUN or STOP) AND (cnt < active_duty), evaluated on the updated cnt: one clk latency after cnt changes.
REQ-024 active_duty=0 gives pwm_out constantly 0; active_duty=PERIOD gives pwm_out constantly 1 across the whole period, including the wrap.
REQ-025 Arithmetic:
- cnt is WIDTH bits.
- Compare is unsigned at WIDTH+1 bits.
- No overflow: cnt never exceeds PERIOD-1.
REQ-026 tick_in edges in IDLE are ignored.

Reset
REQ-027 rst_n low, asynchronous, sets all of the following at any time, including mid-period:
- state=IDLE, cnt=0, tick_q=0
- active_duty=0, pend_full=0, pending=0
- pwm_out=0, period_start=0, running=0
- duty_ready=1
REQ-028 After rst_n release, the first step is detected only on a rising tick_in edge seen after release.

Structure
REQ-029 Shared package pwm_pkg holds:
- typedef pwm_state_t {IDLE, RUN, STOP}
- default WIDTH/PERIOD constants.
REQ-030 One sub-module, tick_edge, implements REQ-013 (register plus rising-edge pulse, async active-low reset); the rest is flat.

Verification
REQ-031 Reset then en=1, duty=4 accepted while IDLE, steady ticks -> period_start pulses; pwm_out high for 4 steps and low for 6 steps of each 10-step period.
REQ-032 Mid-period, accept duty=7 -> duty_ready drops; current period keeps 4 high; next period shows 7 high; duty_ready returns high at that period_start.
REQ-033 duty=0, then duty=15 (saturates to 10) -> one full period of constant 0, then constant 1 with no glitch across the wrap.
REQ-034 en=0 at cnt=3 -> period completes through cnt=9; state goes to IDLE with no period_start; pwm_out=0. Separately, en re-asserted at cnt=6 -> seamless continuation.
REQ-035 rst_n pulsed low at cnt=5 with pending full -> all outputs take reset values immediately; duty_ready=1; no step until a new tick_in rising edge.
REQ-036 tick_in held high for 20 clk -> exactly one step.
